// File: rtl/dffp_share_arbiter.sv
// Round-robin arbiter that is the sole writer of a shared WIDTH-bit register bank.
// Optional requester lock (DFFP_SHARE_ARB_LOCK_EN) lets a granted requester keep the bank.

module dffp_share_arb_slot #(
  parameter int WIDTH = 8
) (
  input  logic             req_bit,
  input  logic             gnt_bit,
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  output logic             eff,
  output logic [WIDTH-1:0] dout
);
  // The requester being acked this cycle sits out one round.
  assign eff  = req_bit & ~gnt_bit;
  assign dout = sel ? din : '0;
endmodule

module dffp_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
`ifdef DFFP_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        last_id,
  output logic                  busy,
  output logic [7:0]            wr_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
`ifdef DFFP_SHARE_ARB_LOCK_EN
    , LOCKED = 2'd2
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr;
  logic [NREQ-1:0]         eff, sel;
  logic [NREQ*WIDTH-1:0]   dout_flat;
  logic [WIDTH-1:0]        wdata;
  logic                    win_vld, hold, take;
  logic [PW-1:0]           win_idx, take_idx, ptr_next;

  dffp_share_arb_slot #(.WIDTH(WIDTH)) u_slot [NREQ-1:0] (
    .req_bit (req),
    .gnt_bit (gnt),
    .sel     (sel),
    .din     (din),
    .eff     (eff),
    .dout    (dout_flat)
  );

  // Rotating first-set search starting at ptr.
  always_comb begin
    int t;
    t       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      t = int'(ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!win_vld && eff[t]) begin
        win_vld = 1'b1;
        win_idx = PW'(t);
      end
    end
  end

`ifdef DFFP_SHARE_ARB_LOCK_EN
  // gnt is one-hot of last_id whenever nonzero, so this tests the acked requester only.
  assign hold = |(gnt & req & lock);
`else
  assign hold = 1'b0;
`endif

  assign take     = hold | win_vld;
  assign take_idx = hold ? last_id[PW-1:0] : win_idx;
  assign ptr_next = (take_idx == PW'(NREQ - 1)) ? '0 : take_idx + PW'(1);

  always_comb begin
    sel = '0;
    if (take) sel[take_idx] = 1'b1;
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) wdata = wdata | dout_flat[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = GRANT;
      default: state_d = take ? GRANT : IDLE;
    endcase
`ifdef DFFP_SHARE_ARB_LOCK_EN
    if (hold) state_d = LOCKED;
`endif
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= '0;
      q        <= '0;
      last_id  <= '0;
      wr_count <= '0;
      ptr      <= '0;
    end else begin
      gnt <= sel;
      if (take) begin
        q        <= wdata;
        last_id  <= IDW'(take_idx);
        wr_count <= wr_count + 8'd1;
        if (!hold) ptr <= ptr_next;
      end
    end
  end
endmodule
